// File: rtl/cfc_frl_ckpt.sv
// ---------------------------------------------------------------------------
// cfc_frl_ckpt
//
// Purpose:
//   Checkpoint-side partner of the free register list (FRL). It keeps a
//   shadow copy of the FRL read pointer by counting PID dispatches. It stores
//   that pointer for every in-flight branch. On a mispredict it rewinds the
//   FRL to the pointer saved at the branch and frees every younger checkpoint.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  synchronous active-high reset
//   du_dispatch_pid        DU pops a PID from the FRL this cycle
//   du_branch_dispatch     DU dispatches a branch this cycle
//   du_branch_tag          tag of the dispatched branch
//   cdb_branch_valid       a branch resolves this cycle
//   cdb_branch_tag         tag of the resolving branch
//   cdb_branch_mispredict  resolving branch mispredicted
//   cfc_flush_frl          one-cycle flush pulse to the FRL
//   cfc_flush_frl_value    restored FRL read pointer
//   cfc_ckpt_full          every checkpoint in use
//   cfc_stall              flush in progress, DU must hold off
//   cfc_mispredict_cnt     saturating count of accepted mispredicts
//                          (only with CFC_MISPREDICT_CNT_EN defined)
//
// Optional feature macro: CFC_MISPREDICT_CNT_EN
// ---------------------------------------------------------------------------
module cfc_frl_ckpt #(
  parameter int FRL_PTR_WIDTH = 5,
  parameter int CKPT_NUM      = 4,
  parameter int TAG_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     du_dispatch_pid,
  input  logic                     du_branch_dispatch,
  input  logic [0:TAG_WIDTH-1]     du_branch_tag,
  input  logic                     cdb_branch_valid,
  input  logic [0:TAG_WIDTH-1]     cdb_branch_tag,
  input  logic                     cdb_branch_mispredict,
  output logic                     cfc_flush_frl,
  output logic [0:FRL_PTR_WIDTH-1] cfc_flush_frl_value,
  output logic                     cfc_ckpt_full,
  output logic                     cfc_stall
`ifdef CFC_MISPREDICT_CNT_EN
  ,
  output logic [0:15]              cfc_mispredict_cnt
`endif
);

  localparam logic [FRL_PTR_WIDTH-1:0] PTR_ONE = {{(FRL_PTR_WIDTH-1){1'b0}}, 1'b1};

  logic [FRL_PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [FRL_PTR_WIDTH-1:0] ckpt_q [CKPT_NUM];
  logic [FRL_PTR_WIDTH-1:0] ckpt_d [CKPT_NUM];
  logic [CKPT_NUM-1:0]      valid_q, valid_d;
  // younger[j][t] = 1 means checkpoint t was allocated after checkpoint j
  logic [CKPT_NUM-1:0][CKPT_NUM-1:0] younger_q, younger_d;
  logic                     flush_q, flush_d;
  logic [FRL_PTR_WIDTH-1:0] flushVal_q, flushVal_d;

  logic                mispAcc;
  logic                resolveOk;
  logic                allocOk;
  logic [CKPT_NUM-1:0] killMask;
  logic [CKPT_NUM-1:0] validAfterFree;

`ifdef CFC_MISPREDICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // Resolve handling is evaluated before allocation, so a tag freed this cycle
  // can be reallocated in the same cycle. The flush cycle blocks all dispatch.
  always_comb begin
    mispAcc   = cdb_branch_valid && cdb_branch_mispredict && valid_q[cdb_branch_tag];
    resolveOk = cdb_branch_valid && !cdb_branch_mispredict && valid_q[cdb_branch_tag];

    killMask = '0;
    if (resolveOk) begin
      killMask[cdb_branch_tag] = 1'b1;
    end
    if (mispAcc) begin
      killMask[cdb_branch_tag] = 1'b1;
      for (int t = 0; t < CKPT_NUM; t++) begin
        if (younger_q[cdb_branch_tag][t] && valid_q[t]) begin
          killMask[t] = 1'b1;
        end
      end
    end
    validAfterFree = valid_q & ~killMask;

    allocOk = du_branch_dispatch && !mispAcc && !flush_q && !validAfterFree[du_branch_tag];

    for (int j = 0; j < CKPT_NUM; j++) begin
      for (int t = 0; t < CKPT_NUM; t++) begin
        younger_d[j][t] = younger_q[j][t] && !killMask[j] && !killMask[t];
      end
    end

    valid_d = validAfterFree;
    ckpt_d  = ckpt_q;
    if (allocOk) begin
      valid_d[du_branch_tag]   = 1'b1;
      ckpt_d[du_branch_tag]    = rptr_q + {{(FRL_PTR_WIDTH-1){1'b0}}, du_dispatch_pid};
      younger_d[du_branch_tag] = '0;
      for (int j = 0; j < CKPT_NUM; j++) begin
        younger_d[j][du_branch_tag] = validAfterFree[j];
      end
    end

    rptr_d = rptr_q;
    if (mispAcc) begin
      rptr_d = ckpt_q[cdb_branch_tag];
    end else if (du_dispatch_pid && !flush_q) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    flush_d    = mispAcc;
    flushVal_d = mispAcc ? ckpt_q[cdb_branch_tag] : flushVal_q;

`ifdef CFC_MISPREDICT_CNT_EN
    cnt_d = cnt_q;
    if (mispAcc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
`endif
  end

  // State registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q     <= '0;
      valid_q    <= '0;
      younger_q  <= '0;
      flush_q    <= 1'b0;
      flushVal_q <= '0;
      for (int i = 0; i < CKPT_NUM; i++) begin
        ckpt_q[i] <= '0;
      end
`ifdef CFC_MISPREDICT_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      rptr_q     <= rptr_d;
      valid_q    <= valid_d;
      younger_q  <= younger_d;
      flush_q    <= flush_d;
      flushVal_q <= flushVal_d;
      for (int i = 0; i < CKPT_NUM; i++) begin
        ckpt_q[i] <= ckpt_d[i];
      end
`ifdef CFC_MISPREDICT_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign cfc_flush_frl       = flush_q;
  assign cfc_flush_frl_value = flushVal_q;
  assign cfc_stall           = flush_q;
  assign cfc_ckpt_full       = &valid_q;
`ifdef CFC_MISPREDICT_CNT_EN
  assign cfc_mispredict_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_cfc_frl_ckpt.sv
// ---------------------------------------------------------------------------
// tb_cfc_frl_ckpt
//
// Directed bench for cfc_frl_ckpt. Each accepted mispredict pushes the
// hand-computed restore pointer into a queue; a monitor pops one entry for
// every flush pulse the DUT produces and flags any pulse nobody expected.
// ---------------------------------------------------------------------------
module tb_cfc_frl_ckpt;

  localparam int W  = 5;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          du_dispatch_pid;
  logic          du_branch_dispatch;
  logic [0:TW-1] du_branch_tag;
  logic          cdb_branch_valid;
  logic [0:TW-1] cdb_branch_tag;
  logic          cdb_branch_mispredict;
  logic          cfc_flush_frl;
  logic [0:W-1]  cfc_flush_frl_value;
  logic          cfc_ckpt_full;
  logic          cfc_stall;
`ifdef CFC_MISPREDICT_CNT_EN
  logic [0:15]   cfc_mispredict_cnt;
`endif

  int           checks = 0;
  int           fails  = 0;
  bit           done   = 1'b0;
  logic [W-1:0] expQ [$];
  logic [W-1:0] expVal;

  cfc_frl_ckpt dut (
    .clk                  (clk),
    .reset                (reset),
    .du_dispatch_pid      (du_dispatch_pid),
    .du_branch_dispatch   (du_branch_dispatch),
    .du_branch_tag        (du_branch_tag),
    .cdb_branch_valid     (cdb_branch_valid),
    .cdb_branch_tag       (cdb_branch_tag),
    .cdb_branch_mispredict(cdb_branch_mispredict),
    .cfc_flush_frl        (cfc_flush_frl),
    .cfc_flush_frl_value  (cfc_flush_frl_value),
    .cfc_ckpt_full        (cfc_ckpt_full),
    .cfc_stall            (cfc_stall)
`ifdef CFC_MISPREDICT_CNT_EN
    ,
    .cfc_mispredict_cnt   (cfc_mispredict_cnt)
`endif
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 unit after the sampling edge
  task automatic applyStimulus(input logic pid, input logic br, input logic [TW-1:0] btag,
                               input logic cv, input logic [TW-1:0] ctag, input logic cm);
    du_dispatch_pid       = pid;
    du_branch_dispatch    = br;
    du_branch_tag         = btag;
    cdb_branch_valid      = cv;
    cdb_branch_tag        = ctag;
    cdb_branch_mispredict = cm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic dispatchPids(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Monitor: the stall output tracks the flush pulse, and every pulse must
  // match the oldest outstanding expected restore pointer.
  always @(negedge clk) begin
    if (!done) begin
      checkOutput("stall_vs_flush", {31'd0, cfc_stall}, {31'd0, cfc_flush_frl});
      if (cfc_flush_frl === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_flush: got pulse value %0d, expected no pulse", cfc_flush_frl_value);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("flush_value", {27'd0, cfc_flush_frl_value}, {27'd0, expVal});
        end
      end
    end
  end

  // Directed scenarios
  initial begin
    reset = 1'b1;
    du_dispatch_pid = 0; du_branch_dispatch = 0; du_branch_tag = 0;
    cdb_branch_valid = 0; cdb_branch_tag = 0; cdb_branch_mispredict = 0;

    // Reset state
    doReset();
    checkOutput("reset_flush", {31'd0, cfc_flush_frl}, 0);
    checkOutput("reset_value", {27'd0, cfc_flush_frl_value}, 0);
    checkOutput("reset_full", {31'd0, cfc_ckpt_full}, 0);
    checkOutput("reset_stall", {31'd0, cfc_stall}, 0);

    // Pointer wrap: 35 dispatches leave the pointer at 3
    dispatchPids(35);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd3);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    checkOutput("wrap_flush_pulse", {31'd0, cfc_flush_frl}, 1);
    idle(1);
    checkOutput("wrap_flush_one_cycle", {31'd0, cfc_flush_frl}, 0);
`ifdef CFC_MISPREDICT_CNT_EN
    checkOutput("cnt_after_one", {16'd0, cfc_mispredict_cnt}, 1);
`endif

    // Nested branches: mispredict tag1 kills younger tag2 as well
    doReset();
    dispatchPids(2);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    dispatchPids(3);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    dispatchPids(4);
    expQ.push_back(5'd2);
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1);
    checkOutput("nested_stall", {31'd0, cfc_stall}, 1);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
    idle(2);

    // Full handling and age ordering
    doReset();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    checkOutput("not_full_3", {31'd0, cfc_ckpt_full}, 0);
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    checkOutput("full_4", {31'd0, cfc_ckpt_full}, 1);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    checkOutput("full_after_realloc", {31'd0, cfc_ckpt_full}, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    checkOutput("full_after_resolve", {31'd0, cfc_ckpt_full}, 0);
    expQ.push_back(5'd2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
    idle(1);
    expQ.push_back(5'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1);
    idle(2);

    // Simultaneous dispatch/branch, then mispredict with a wrong-path dispatch
    doReset();
    dispatchPids(7);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd8);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    checkOutput("simul_stall_on", {31'd0, cfc_stall}, 1);
    idle(1);
    checkOutput("simul_stall_off", {31'd0, cfc_stall}, 0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd8);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1);
    idle(2);

    // Resolve and reallocate the same tag in one cycle
    doReset();
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    dispatchPids(5);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0);
    expQ.push_back(5'd5);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
    idle(2);

    // Reset in the flush cycle
    doReset();
    dispatchPids(4);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd4);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("rst_mid_flush", {31'd0, cfc_flush_frl}, 0);
    checkOutput("rst_mid_full", {31'd0, cfc_ckpt_full}, 0);
`ifdef CFC_MISPREDICT_CNT_EN
    checkOutput("rst_mid_cnt", {16'd0, cfc_mispredict_cnt}, 0);
`endif
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    expQ.push_back(5'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1);
    idle(3);

    done = 1'b1;
    checkOutput("pulses_outstanding", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
